// File: rtl/lock_reg_bank_ctrl_if.sv
// Write-request handshake bundle for one requester port of lock_reg_bank_ctrl.
interface lock_reg_bank_ctrl_if #(
    parameter int unsigned AW = 2
);
    logic          req;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic          lock;
    logic          ack;
    logic          err;

    modport master (output req, addr, wdata, lock, input ack, err);
    modport slave  (input req, addr, wdata, lock, output ack, err);
endinterface

// File: rtl/lock_reg_bank_ctrl.sv
// Arbitrated write controller for a bank of lockable 16-bit config registers,
// with a host port (A), a debug port (B) and a qualified debug lock override.
module lock_reg_bank_ctrl #(
    parameter int unsigned     NREG         = 4,
    parameter int unsigned     AW           = 2,
    parameter logic [NREG-1:0] DBG_OVR_MASK = NREG'(1),
    parameter logic [15:0]     RST_VAL      = 16'h0000
) (
    input  logic                     Clk,
    input  logic                     resetn,
    lock_reg_bank_ctrl_if.slave      port_a,
    lock_reg_bank_ctrl_if.slave      port_b,
    input  logic                     scan_mode,
    input  logic                     debug_unlocked,
    output logic [NREG*16-1:0]       reg_out,
    output logic [NREG-1:0]          lock_status,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                 state_q, state_d;
    logic                   rr_q, rr_d;      // 0 = A next, 1 = B next
    logic                   gnt_q, gnt_d;    // 0 = A, 1 = B
    logic [AW-1:0]          addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic                   lk_q, lk_d;
    logic                   err_q, err_d;
    logic                   ack_a_q, ack_a_d, err_a_q, err_a_d;
    logic                   ack_b_q, ack_b_d, err_b_q, err_b_d;
    logic [NREG-1:0][15:0]  regs_q, regs_d;
    logic [NREG-1:0]        lock_q, lock_d;

    logic hit, hit_locked, hit_ovr, exec_err;

    // Address decode by comparison keeps out-of-range indices away from the arrays.
    always_comb begin
        hit        = 1'b0;
        hit_locked = 1'b0;
        hit_ovr    = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (addr_q == AW'(i)) begin
                hit        = 1'b1;
                hit_locked = lock_q[i];
                hit_ovr    = DBG_OVR_MASK[i];
            end
        end
        exec_err = scan_mode || !hit ||
                   (hit_locked && !(gnt_q && debug_unlocked && hit_ovr));
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lk_d    = lk_q;
        err_d   = err_q;
        regs_d  = regs_q;
        lock_d  = lock_q;
        ack_a_d = 1'b0;
        err_a_d = 1'b0;
        ack_b_d = 1'b0;
        err_b_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (port_a.req || port_b.req) begin
                    gnt_d   = (port_a.req && port_b.req) ? rr_q : port_b.req;
                    rr_d    = !gnt_d;
                    addr_d  = gnt_d ? port_b.addr  : port_a.addr;
                    wdata_d = gnt_d ? port_b.wdata : port_a.wdata;
                    lk_d    = gnt_d ? port_b.lock  : port_a.lock;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                err_d = exec_err;
                if (!exec_err) begin
                    for (int unsigned i = 0; i < NREG; i++) begin
                        if (addr_q == AW'(i)) begin
                            regs_d[i] = wdata_q;
                            if (lk_q) lock_d[i] = 1'b1;
                        end
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                if (gnt_q) begin
                    ack_b_d = 1'b1;
                    err_b_d = err_q;
                end else begin
                    ack_a_d = 1'b1;
                    err_a_d = err_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lk_q    <= 1'b0;
            err_q   <= 1'b0;
            ack_a_q <= 1'b0;
            err_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            err_b_q <= 1'b0;
            regs_q  <= {NREG{RST_VAL}};
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lk_q    <= lk_d;
            err_q   <= err_d;
            ack_a_q <= ack_a_d;
            err_a_q <= err_a_d;
            ack_b_q <= ack_b_d;
            err_b_q <= err_b_d;
            regs_q  <= regs_d;
            lock_q  <= lock_d;
        end
    end

    assign port_a.ack  = ack_a_q;
    assign port_a.err  = err_a_q;
    assign port_b.ack  = ack_b_q;
    assign port_b.err  = err_b_q;
    assign reg_out     = regs_q;
    assign lock_status = lock_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_lock_reg_bank_ctrl.sv
// Directed, table-driven bench for lock_reg_bank_ctrl (NREG=4, AW=3 for out-of-range tests).
module tb_lock_reg_bank_ctrl;

    localparam int unsigned NREG = 4;
    localparam int unsigned AW   = 3;

    logic                 Clk = 1'b0;
    logic                 resetn;
    logic                 scan_mode;
    logic                 debug_unlocked;
    logic [NREG*16-1:0]   reg_out;
    logic [NREG-1:0]      lock_status;
    logic                 busy;

    always #5 Clk = ~Clk;

    lock_reg_bank_ctrl_if #(.AW(AW)) pa ();
    lock_reg_bank_ctrl_if #(.AW(AW)) pb ();

    lock_reg_bank_ctrl #(
        .NREG(NREG),
        .AW(AW),
        .DBG_OVR_MASK(4'b0001),
        .RST_VAL(16'h0000)
    ) u_dut (
        .Clk(Clk),
        .resetn(resetn),
        .port_a(pa),
        .port_b(pb),
        .scan_mode(scan_mode),
        .debug_unlocked(debug_unlocked),
        .reg_out(reg_out),
        .lock_status(lock_status),
        .busy(busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        resetn = 1'b1;
    endtask

    // One transaction: ack must arrive on the 3rd sampling edge and last one cycle.
    task automatic xact(input bit port, input logic [AW-1:0] addr, input logic [15:0] wd,
                        input logic lk, input logic exp_err, input string tag);
        int lat;
        bit seen;
        @(negedge Clk);
        if (!port) begin
            pa.req = 1'b1; pa.addr = addr; pa.wdata = wd; pa.lock = lk;
        end else begin
            pb.req = 1'b1; pb.addr = addr; pb.wdata = wd; pb.lock = lk;
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge Clk);
            lat++;
            if (port ? pb.ack : pa.ack) seen = 1'b1;
        end
        check({tag, " latency"}, 64'(lat), 64'd3);
        check({tag, " err"}, 64'(port ? pb.err : pa.err), 64'(exp_err));
        if (!port) begin
            pa.req = 1'b0; pa.addr = '1; pa.wdata = 16'hDEAD;
        end else begin
            pb.req = 1'b0; pb.addr = '1; pb.wdata = 16'hDEAD;
        end
        @(negedge Clk);
        check({tag, " ack single"}, 64'(port ? pb.ack : pa.ack), 64'd0);
    endtask

    typedef struct {
        bit              port;
        logic [AW-1:0]   addr;
        logic [15:0]     wd;
        logic            lk;
        logic            scan;
        logic            dbg;
        logic            exp_err;
        logic [63:0]     exp_reg;
        logic [3:0]      exp_lock;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int acks;
        int order [4];
        bit prev_ack;
        bit dbl;

        pa.req = 1'b0; pa.addr = '0; pa.wdata = '0; pa.lock = 1'b0;
        pb.req = 1'b0; pb.addr = '0; pb.wdata = '0; pb.lock = 1'b0;
        scan_mode = 1'b0;
        debug_unlocked = 1'b0;

        //           port addr wd        lk scan dbg err  reg_out {r3,r2,r1,r0}   lock
        tbl[0]  = '{1'b0, 3'd1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0000_0000_BEEF_0000, 4'b0000};
        tbl[1]  = '{1'b0, 3'd2, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0000_1234_BEEF_0000, 4'b0100};
        tbl[2]  = '{1'b0, 3'd2, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_1234_BEEF_0000, 4'b0100};
        tbl[3]  = '{1'b0, 3'd0, 16'h0F0F, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0000_1234_BEEF_0F0F, 4'b0101};
        tbl[4]  = '{1'b1, 3'd0, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0000_1234_BEEF_AAAA, 4'b0101};
        tbl[5]  = '{1'b1, 3'd0, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_1234_BEEF_AAAA, 4'b0101};
        tbl[6]  = '{1'b0, 3'd0, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0000_1234_BEEF_AAAA, 4'b0101};
        tbl[7]  = '{1'b0, 3'd3, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0000_1234_BEEF_AAAA, 4'b0101};
        tbl[8]  = '{1'b0, 3'd5, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_1234_BEEF_AAAA, 4'b0101};
        tbl[9]  = '{1'b1, 3'd2, 16'h7777, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0000_1234_BEEF_AAAA, 4'b0101};
        tbl[10] = '{1'b1, 3'd0, 16'hCCCC, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0000_1234_BEEF_CCCC, 4'b0101};
        tbl[11] = '{1'b1, 3'd3, 16'h3333, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_1234_BEEF_CCCC, 4'b0101};
        tbl[12] = '{1'b1, 3'd3, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 64'hABCD_1234_BEEF_CCCC, 4'b0101};

        do_reset();
        check("rst reg_out", reg_out, 64'h0);
        check("rst lock", 64'(lock_status), 64'h0);
        check("rst busy", 64'(busy), 64'h0);
        check("rst acks", 64'({pa.ack, pa.err, pb.ack, pb.err}), 64'h0);

        for (int i = 0; i < 13; i++) begin
            scan_mode      = tbl[i].scan;
            debug_unlocked = tbl[i].dbg;
            xact(tbl[i].port, tbl[i].addr, tbl[i].wd, tbl[i].lk, tbl[i].exp_err,
                 $sformatf("v%0d", i));
            check($sformatf("v%0d reg_out", i), reg_out, tbl[i].exp_reg);
            check($sformatf("v%0d lock", i), 64'(lock_status), 64'(tbl[i].exp_lock));
        end
        scan_mode      = 1'b0;
        debug_unlocked = 1'b0;

        // Reset during EXEC of a locked-register override write.
        do_reset();
        xact(1'b0, 3'd0, 16'h0F0F, 1'b1, 1'b0, "pre-lock");
        check("pre-lock lock", 64'(lock_status), 64'h1);
        debug_unlocked = 1'b1;
        @(negedge Clk);
        pb.req = 1'b1; pb.addr = 3'd0; pb.wdata = 16'h9999; pb.lock = 1'b1;
        @(negedge Clk);
        check("abort busy before", 64'(busy), 64'h1);
        resetn = 1'b0;
        pb.req = 1'b0;
        #1;
        check("abort reg_out", reg_out, 64'h0);
        check("abort lock", 64'(lock_status), 64'h0);
        check("abort busy", 64'(busy), 64'h0);
        @(negedge Clk);
        resetn = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge Clk);
            if (pb.ack || pa.ack) acks++;
        end
        check("abort no ack", 64'(acks), 64'h0);
        check("abort reg_out after", reg_out, 64'h0);
        debug_unlocked = 1'b0;

        // Both requests held from reset: grants alternate A,B,A,B.
        resetn = 1'b0;
        pa.req = 1'b1; pa.addr = 3'd1; pa.wdata = 16'h1111; pa.lock = 1'b0;
        pb.req = 1'b1; pb.addr = 3'd2; pb.wdata = 16'h2222; pb.lock = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        resetn = 1'b1;
        acks     = 0;
        prev_ack = 1'b0;
        dbl      = 1'b0;
        for (int c = 0; c < 60 && acks < 4; c++) begin
            @(negedge Clk);
            if (pa.ack && pb.ack) dbl = 1'b1;
            if (prev_ack && (pa.ack || pb.ack)) dbl = 1'b1;
            if (pa.ack || pb.ack) begin
                order[acks] = pb.ack ? 1 : 0;
                check($sformatf("rr err %0d", acks), 64'(pa.err | pb.err), 64'h0);
                acks++;
            end
            prev_ack = pa.ack || pb.ack;
        end
        pa.req = 1'b0;
        pb.req = 1'b0;
        check("rr ack count", 64'(acks), 64'd4);
        check("rr order", 64'({order[0][0], order[1][0], order[2][0], order[3][0]}), 64'b0101);
        check("rr single-cycle acks", 64'(dbl), 64'h0);
        check("rr reg_out", reg_out, 64'h0000_2222_1111_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lock_reg_bank_ctrl.md
Name: lock_reg_bank_ctrl

Overview:
Write-access controller for a bank of NREG 16-bit lockable configuration registers. It arbitrates between a host requester (port A) and a debug requester (port B), and enforces per-register sticky lock bits. It applies a strictly qualified debug override. Scan mode never bypasses a lock. It sits between the bus-side requesters and the security-sensitive configuration registers that feed the datapath.

Parameters:
NREG, 4, number of 16-bit registers in the bank (2..16)
AW, 2, address width, must satisfy 2**AW >= NREG
DBG_OVR_MASK, 4'b0001, per-register bit; 1 = port B may write this register while it is locked, only when debug_unlocked=1
RST_VAL, 16'h0000, reset value of every register

Ports:
Clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_a  in  1  host write request, level, held until ack_a
addr_a  in  AW  host target register index
wdata_a  in  16  host write data
lock_a  in  1  host: set the lock bit after the write
ack_a  out  1  host completion pulse, one cycle
err_a  out  1  valid with ack_a; 1 = write rejected
req_b, addr_b, wdata_b, lock_b, ack_b, err_b  same as port A, for the debug requester
scan_mode  in  1  scan active; all writes rejected
debug_unlocked  in  1  debug authentication passed
reg_out  out  NREG*16  register contents; register i occupies bits [16i+15:16i]
lock_status  out  NREG  per-register lock bit
busy  out  1  FSM not in IDLE

Behaviour:
- Reset, asynchronous, active-low:
  - reg_out = RST_VAL for every register; lock_status = 0.
  - ack_a/b = 0, err_a/b = 0, busy = 0.
  - FSM goes to IDLE; round-robin pointer rr = A.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the port named by rr, then set rr to the other port.
  - A single request also sets rr to the non-granted port.
  - On grant, latch addr, wdata, lock and the granted-port id, then go to EXEC.
  - With no req, stay in IDLE.
- EXEC (one cycle): evaluate the write using the latched values.
  - Error cases, checked in priority order:
    - scan_mode = 1.
    - addr >= NREG.
    - lock_status[addr] = 1 and the override is not allowed.
  - The override is allowed only when the port is B AND debug_unlocked = 1 AND DBG_OVR_MASK[addr] = 1. Port A never overrides.
  - No error: write reg[addr] = wdata at this clock edge. If lock = 1, also set lock_status[addr].
  - Error: no register or lock state changes.
  - Go to RESP.
- RESP (one cycle):
  - Pulse ack of the granted port for exactly one cycle; err of that port = the error result.
  - Return to IDLE.
- Latency: req seen in IDLE at edge N; register updated at edge N+1; ack high during the cycle after edge N+2. Minimum 3 cycles per transaction.
- Requester handshake:
  - The requester drops req in the cycle ack is high.
  - If req is still high in IDLE after the ack, it is a new transaction.
  - Changing addr/wdata while waiting has no effect after the grant.
- The ungranted requester waits; its req is not lost. With both requests held continuously, grants strictly alternate.
- Lock bits:
  - Sticky; only reset clears them.
  - lock = 1 on an already-locked register, via a permitted override, rewrites data; the lock stays 1.
- scan_mode and debug_unlocked are sampled in EXEC only.
- Reset mid-transaction aborts it: no ack is issued and no partial write occurs.
- reg_out and lock_status are registered outputs that change only at the EXEC edge.

Test Plan:
- Reset, then A writes addr 1 = 16'hBEEF with lock=0 -> ack_a after 3 cycles, err_a=0, reg1=BEEF, lock_status=0000.
- A writes addr 2 = 16'h1234 with lock=1, then A writes addr 2 = 16'h5555 -> second ack has err_a=1; reg2 stays 1234; lock_status[2]=1.
- Lock reg0; B writes 16'hAAAA with debug_unlocked=1 -> err_b=0, reg0=AAAA. Repeat with debug_unlocked=0, and from port A -> err=1, reg0 unchanged.
- scan_mode=1, A writes unlocked addr 3 -> err_a=1, reg3 unchanged. Also NREG=4 with addr out of range (use AW=3 and addr 5) -> err=1.
- req_a and req_b held simultaneously from reset for 4 transactions -> grant order A, B, A, B; each ack is a single cycle.
- Assert resetn low during EXEC of a locked-register override write -> no ack; all registers RST_VAL; lock_status all 0; busy=0.
